// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core's decode stage: register indexing,
// decode field widths and the hazard-controller state encoding.
package core_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned NREGS       = 32;
  localparam int unsigned CTRL_OP_W   = 4;
  localparam int unsigned IMM_W       = 7;
  localparam int unsigned FLUSH_CNT_W = 3;
  localparam int unsigned PERF_W      = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/decode_hazard_ctrl_scoreboard.sv
// Pending-write scoreboard (reg_scoreboard): one bit per register, set on issue,
// cleared on writeback, with two lookup ports that see a same-cycle WB as already done.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set_en,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr_en,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  input  logic [REG_IDX_W-1:0] i_rd_idx_a,
  input  logic [REG_IDX_W-1:0] i_rd_idx_b,
  output logic                 o_hit_a_c,
  output logic                 o_hit_b_c,
  output logic [NREGS-1:0]     o_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_pending_nxt;

  // Clear before set so a new producer to the same register wins.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
    if (R0_ZERO) begin
      w_set_mask[0] = 1'b0;
      w_clr_mask[0] = 1'b0;
    end
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  // The register file writes before it is read, so a retiring WB masks the hit.
  assign o_hit_a_c = r_pending[i_rd_idx_a] & ~w_clr_mask[i_rd_idx_a]
                     & ~(R0_ZERO && (i_rd_idx_a == '0));
  assign o_hit_b_c = r_pending[i_rd_idx_b] & ~w_clr_mask[i_rd_idx_b]
                     & ~(R0_ZERO && (i_rd_idx_b == '0));

  assign o_pending = r_pending;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: stalls IF/ID on RAW hazards against the
// scoreboard and turns EX mispredicts into a timed IF/ID flush.
module decode_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          R0_ZERO      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_rd_wr,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 ex_mispredict,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 flush_ifid,
  output logic                 issue,
  output logic [NREGS-1:0]     pending,
  output logic [PERF_W-1:0]    stall_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;
  logic                   r_flush_ifid;
  logic [PERF_W-1:0]      r_stall_cnt;
  logic                   w_hit1;
  logic                   w_hit2;
  logic                   w_hazard;
  logic                   w_stall;
  logic                   w_issue;

  reg_scoreboard #(
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_issue & id_rd_wr),
    .i_set_idx  (id_rd),
    .i_clr_en   (wb_valid),
    .i_clr_idx  (wb_rd),
    .i_rd_idx_a (id_rs1),
    .i_rd_idx_b (id_rs2),
    .o_hit_a_c  (w_hit1),
    .o_hit_b_c  (w_hit2),
    .o_pending  (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_flush_cnt  <= '0;
      r_flush_ifid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_flush_ifid <= (w_state_nxt == FLUSH);
    end
  end

  // Next state and decode handshake; a mispredict squashes whatever sits in ID.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_hazard        = id_valid & ((id_rs1_used & w_hit1) | (id_rs2_used & w_hit2));
    w_stall         = 1'b0;
    w_issue         = 1'b0;
    case (r_state)
      RUN: begin
        w_stall = w_hazard & ~ex_mispredict;
        w_issue = id_valid & ~w_hazard & ~ex_mispredict;
        if (ex_mispredict) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (ex_mispredict) begin
          w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (r_flush_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {PERF_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign stall_if   = w_stall;
  assign stall_id   = w_stall;
  assign issue      = w_issue;
  assign flush_ifid = r_flush_ifid;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: directed scenarios plus random
// traffic, all compared each cycle against a behavioural scoreboard/flush model.
module tb_decode_hazard_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wr, wb_valid, ex_mispredict;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        stall_if, stall_id, flush_ifid, issue;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  bit m_pend [32];
  int m_flush_left;
  int m_scnt;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.FLUSH_CYCLES(FC), .R0_ZERO(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_rd         (id_rd),
    .id_rd_wr      (id_rd_wr),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .ex_mispredict (ex_mispredict),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush_ifid    (flush_ifid),
    .issue         (issue),
    .pending       (pending),
    .stall_cnt     (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_flush_left = 0;
    m_scnt       = 0;
  endfunction

  // A source is busy if a write is outstanding and is not retiring this very cycle.
  function automatic bit busy(input int idx);
    return (idx != 0) && m_pend[idx] && !(wb_valid && (int'(wb_rd) == idx));
  endfunction

  // Check one cycle (inputs already driven after negedge), advance model, step to next negedge.
  task automatic run_cycle();
    bit          hz, es, ei, ef;
    logic [31:0] pv;
    #2;
    ef = (m_flush_left > 0);
    hz = id_valid && ((id_rs1_used && busy(int'(id_rs1))) || (id_rs2_used && busy(int'(id_rs2))));
    es = hz && !ef && !ex_mispredict;
    ei = id_valid && !hz && !ef && !ex_mispredict;
    for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
    chk("stall_id",   32'(stall_id),   32'(es));
    chk("stall_if",   32'(stall_if),   32'(es));
    chk("issue",      32'(issue),      32'(ei));
    chk("flush_ifid", 32'(flush_ifid), 32'(ef));
    chk("pending",    pending,         pv);
    chk("stall_cnt",  32'(stall_cnt),  32'(m_scnt));
    if (wb_valid && wb_rd != 5'd0) m_pend[wb_rd] = 1'b0;
    if (ei && id_rd_wr && id_rd != 5'd0) m_pend[id_rd] = 1'b1;
    if (ex_mispredict) m_flush_left = FC;
    else if (m_flush_left > 0) m_flush_left--;
    if (es && m_scnt < 65535) m_scnt++;
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                       input bit u2, input logic [4:0] rd, input bit wr, input bit wv,
                       input logic [4:0] wrd, input bit mis);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_rd_wr = wr; wb_valid = wv; wb_rd = wrd; ex_mispredict = mis;
    run_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wr = 0; wb_valid = 0; wb_rd = 0; ex_mispredict = 0;
    model_reset();
    @(negedge clk);
    #2;
    chk("rst_pending",   pending,           32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt),    32'h0);
    chk("rst_flush",     32'(flush_ifid),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW stall on rd=3, then released by a same-cycle WB of r3
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    idle(1);

    // r0 is never pending and never stalls
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Mispredict with a hazard in ID; squashed op writes r9
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    drive(1, 6, 1, 0, 0, 9, 1, 0, 0, 1);
    drive(1, 6, 1, 0, 0, 9, 1, 0, 0, 0);
    drive(1, 6, 1, 0, 0, 9, 1, 0, 0, 0);
    drive(1, 6, 1, 0, 0, 9, 1, 1, 6, 0);
    idle(1);

    // Clear and set the same register in one cycle
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);

    // Mispredict again on the last flush cycle extends the flush
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-flush with pending = 0x18
    for (int i = 1; i < 32; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    id_valid = 0; ex_mispredict = 0; wb_valid = 0; id_rd_wr = 0;
    #2;
    chk("pre_rst_flush",   32'(flush_ifid), 32'h1);
    chk("pre_rst_pending", pending,         32'h18);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_flush",     32'(flush_ifid), 32'h0);
    chk("async_rst_pending",   pending,         32'h0);
    chk("async_rst_stall_cnt", 32'(stall_cnt),  32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Long stall saturates the perf counter
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    id_valid = 1; id_rs1 = 7; id_rs1_used = 1; id_rd_wr = 0;
    for (int n = 0; n < 65540; n++) run_cycle();
    chk("stall_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);
    drive(1, 7, 1, 0, 0, 0, 0, 1, 7, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
